// File: rtl/fifo_flags_if.sv
// Bundled request/response signals of the fifo_flags buffer.
// Handshake: i_wr/i_rd are requests taken on a rising edge when i_en=1 and i_clr=0; o_valid qualifies o_data.
interface fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  i_en;
  logic                  i_clr;
  logic                  i_wr;
  logic                  i_rd;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic [ADDR_WIDTH:0]   o_level;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_afull;
  logic                  o_aempty;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_en, i_clr, i_wr, i_rd, i_data,
    input  o_data, o_valid, o_level, o_full, o_empty, o_afull, o_aempty,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_en, i_clr, i_wr, i_rd, i_data,
    output o_data, o_valid, o_level, o_full, o_empty, o_afull, o_aempty,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with level count, threshold flags, sticky errors and flush.
// Define FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read port.
module fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 2,
  parameter int OVERWRITE_OLD = 0,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  fifo_flags_if.slave bus
);
  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic                OVW_EN   = (OVERWRITE_OLD != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  logic act;
  logic is_full;
  logic is_empty;
  logic rd_ok;
  logic wr_room;
  logic wr_both;
  logic wr_ovw;
  logic wr_ok;
  logic ovf_set;
  logic udf_set;
  logic lvl_inc;
  logic lvl_dec;

  always_comb begin
    act      = bus.i_en && !bus.i_clr;
    is_full  = (level == DEPTH_L);
    is_empty = (level == '0);
    rd_ok    = act && bus.i_rd && !is_empty;
    wr_room  = act && bus.i_wr && !is_full;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    wr_both  = act && bus.i_wr && is_full && rd_ok;
    wr_ovw   = act && bus.i_wr && is_full && !bus.i_rd && OVW_EN;
    wr_ok    = wr_room || wr_both || wr_ovw;
    ovf_set  = act && bus.i_wr && is_full && !bus.i_rd;
    udf_set  = act && bus.i_rd && is_empty;
    lvl_inc  = wr_room && !rd_ok;
    lvl_dec  = rd_ok && !wr_ok;
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr] <= bus.i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.i_en) begin
      if (bus.i_clr) begin
        wptr      <= '0;
        rptr      <= '0;
        level     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        // Overwrite drops the oldest word by moving the read pointer past it.
        if (rd_ok || wr_ovw) rptr <= rptr + 1'b1;
        if (lvl_inc) level <= level + 1'b1;
        else if (lvl_dec) level <= level - 1'b1;
        if (ovf_set) overflow <= 1'b1;
        if (udf_set) underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.o_data  = mem[rptr];
  assign bus.o_valid = !is_empty;
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_ok;
      if (rd_ok) data_q <= mem[rptr];
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
`endif

  assign bus.o_level     = level;
  assign bus.o_full      = is_full;
  assign bus.o_empty     = is_empty;
  assign bus.o_afull     = (level >= AFULL_L);
  assign bus.o_aempty    = (level <= AEMPTY_L);
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
endmodule

// File: tb/tb_fifo_flags.sv
// Directed, table-driven bench for fifo_flags (registered read port build).
// Instance a uses reject-on-full; instance b uses overwrite-oldest.
module tb_fifo_flags;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_a ();
  fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_b ();

  fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .OVERWRITE_OLD(0),
               .AFULL_THRESH(3), .AEMPTY_THRESH(1))
    dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));

  fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .OVERWRITE_OLD(1),
               .AFULL_THRESH(3), .AEMPTY_THRESH(1))
    dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // op = {en, clr, wr, rd}; st = {overflow, underflow, valid}
  typedef struct {
    logic [3:0] op;
    logic [7:0] din;
    logic [2:0] lvl;
    logic [2:0] st;
    logic       chk;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic [3:0] op, input logic [7:0] din);
    {bus_a.i_en, bus_a.i_clr, bus_a.i_wr, bus_a.i_rd} = op;
    bus_a.i_data = din;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [3:0] op, input logic [7:0] din);
    {bus_b.i_en, bus_b.i_clr, bus_b.i_wr, bus_b.i_rd} = op;
    bus_b.i_data = din;
    @(posedge clk);
    #1;
  endtask

  // Level flags follow directly from the level for depth 4, afull 3, aempty 1.
  task automatic chk_level_a(input string nm, input logic [2:0] lvl);
    chk({nm, " level"},  32'(bus_a.o_level),  32'(lvl));
    chk({nm, " full"},   32'(bus_a.o_full),   32'(lvl == 3'd4));
    chk({nm, " empty"},  32'(bus_a.o_empty),  32'(lvl == 3'd0));
    chk({nm, " afull"},  32'(bus_a.o_afull),  32'(lvl >= 3'd3));
    chk({nm, " aempty"}, 32'(bus_a.o_aempty), 32'(lvl <= 3'd1));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    {bus_a.i_en, bus_a.i_clr, bus_a.i_wr, bus_a.i_rd} = 4'b0000;
    {bus_b.i_en, bus_b.i_clr, bus_b.i_wr, bus_b.i_rd} = 4'b0000;
    bus_a.i_data = 8'h00;
    bus_b.i_data = 8'h00;

    vecs[0]  = '{4'b1010, 8'h15, 3'd1, 3'b000, 1'b0, 8'h00};
    vecs[1]  = '{4'b1010, 8'h16, 3'd2, 3'b000, 1'b0, 8'h00};
    vecs[2]  = '{4'b1010, 8'h17, 3'd3, 3'b000, 1'b0, 8'h00};
    vecs[3]  = '{4'b1010, 8'h18, 3'd4, 3'b000, 1'b0, 8'h00};
    vecs[4]  = '{4'b1010, 8'h19, 3'd4, 3'b100, 1'b0, 8'h00};
    vecs[5]  = '{4'b1001, 8'h00, 3'd3, 3'b101, 1'b1, 8'h15};
    vecs[6]  = '{4'b1001, 8'h00, 3'd2, 3'b101, 1'b1, 8'h16};
    vecs[7]  = '{4'b1001, 8'h00, 3'd1, 3'b101, 1'b1, 8'h17};
    vecs[8]  = '{4'b1001, 8'h00, 3'd0, 3'b101, 1'b1, 8'h18};
    vecs[9]  = '{4'b1000, 8'h00, 3'd0, 3'b100, 1'b1, 8'h18};
    vecs[10] = '{4'b1001, 8'h00, 3'd0, 3'b110, 1'b1, 8'h18};
    vecs[11] = '{4'b1010, 8'h21, 3'd1, 3'b110, 1'b0, 8'h00};
    vecs[12] = '{4'b1010, 8'h22, 3'd2, 3'b110, 1'b0, 8'h00};
    vecs[13] = '{4'b1111, 8'h23, 3'd0, 3'b000, 1'b1, 8'h18};
    vecs[14] = '{4'b1010, 8'h31, 3'd1, 3'b000, 1'b0, 8'h00};
    vecs[15] = '{4'b1010, 8'h32, 3'd2, 3'b000, 1'b0, 8'h00};
    vecs[16] = '{4'b1011, 8'h33, 3'd2, 3'b001, 1'b1, 8'h31};
    vecs[17] = '{4'b1011, 8'h34, 3'd2, 3'b001, 1'b1, 8'h32};
    vecs[18] = '{4'b1010, 8'h35, 3'd3, 3'b000, 1'b0, 8'h00};
    vecs[19] = '{4'b1010, 8'h36, 3'd4, 3'b000, 1'b0, 8'h00};
    vecs[20] = '{4'b1011, 8'h37, 3'd4, 3'b001, 1'b1, 8'h33};
    vecs[21] = '{4'b0011, 8'h99, 3'd4, 3'b000, 1'b1, 8'h33};
    vecs[22] = '{4'b1001, 8'h00, 3'd3, 3'b001, 1'b1, 8'h34};
    vecs[23] = '{4'b1001, 8'h00, 3'd2, 3'b001, 1'b1, 8'h35};
    vecs[24] = '{4'b1001, 8'h00, 3'd1, 3'b001, 1'b1, 8'h36};
    vecs[25] = '{4'b1001, 8'h00, 3'd0, 3'b001, 1'b1, 8'h37};

    // Reset values before any clock edge.
    #2;
    chk_level_a("reset", 3'd0);
    chk("reset data",  32'(bus_a.o_data),      32'h0);
    chk("reset valid", 32'(bus_a.o_valid),     32'h0);
    chk("reset ovf",   32'(bus_a.o_overflow),  32'h0);
    chk("reset udf",   32'(bus_a.o_underflow), 32'h0);
    #6;
    rst_n = 1'b1;
    bus_b.i_en = 1'b1;

    for (int i = 0; i < 26; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive_a(vecs[i].op, vecs[i].din);
      chk_level_a(nm, vecs[i].lvl);
      chk({nm, " ovf"},   32'(bus_a.o_overflow),  32'(vecs[i].st[2]));
      chk({nm, " udf"},   32'(bus_a.o_underflow), 32'(vecs[i].st[1]));
      chk({nm, " valid"}, 32'(bus_a.o_valid),     32'(vecs[i].st[0]));
      if (vecs[i].chk) chk({nm, " data"}, 32'(bus_a.o_data), 32'(vecs[i].dout));
    end

    // Asynchronous reset between edges with three words stored.
    drive_a(4'b1010, 8'h41);
    drive_a(4'b1010, 8'h42);
    drive_a(4'b1010, 8'h43);
    chk_level_a("pre_rst", 3'd3);
    drive_a(4'b1000, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    chk_level_a("async_rst", 3'd0);
    chk("async_rst data",  32'(bus_a.o_data),  32'h0);
    chk("async_rst valid", 32'(bus_a.o_valid), 32'h0);
    #2;
    rst_n = 1'b1;
    bus_b.i_en = 1'b1;
    drive_a(4'b1010, 8'hA5);
    chk_level_a("post_rst wr", 3'd1);
    drive_a(4'b1001, 8'h00);
    chk("post_rst valid", 32'(bus_a.o_valid), 32'h1);
    chk("post_rst data",  32'(bus_a.o_data),  32'hA5);
    drive_a(4'b1000, 8'h00);

    // Overwrite-oldest instance: six writes keep the newest four.
    for (int k = 0; k < 6; k++) drive_b(4'b1010, 8'(8'h11 + k));
    chk("ovw level", 32'(bus_b.o_level),    32'd4);
    chk("ovw ovf",   32'(bus_b.o_overflow), 32'h1);
    chk("ovw full",  32'(bus_b.o_full),     32'h1);
    for (int k = 0; k < 4; k++) begin
      drive_b(4'b1001, 8'h00);
      chk($sformatf("ovw rd%0d valid", k), 32'(bus_b.o_valid), 32'h1);
      chk($sformatf("ovw rd%0d data", k),  32'(bus_b.o_data),  32'(8'h13 + k));
    end
    chk("ovw empty", 32'(bus_b.o_empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO for buffering decimated sigma-delta samples between the modulator/decimator and the readout interface. It is the next generation of the team's basic FIFO and adds:
- occupancy count and programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- optional overwrite-oldest mode
- optional first-word-fall-through read port

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 2: address bits; DEPTH = 2^ADDR_WIDTH; legal range ≥ 1.
- OVERWRITE_OLD, 0: 1 = a write when full discards the oldest word; 0 = the write is rejected.
- AFULL_THRESH, 3: o_afull asserts at level ≥ this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: o_aempty asserts at level ≤ this value; legal range 0..DEPTH-1.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  global enable; 0 = all state held, o_valid forced 0 next edge.
- i_clr  in  1  synchronous flush (requires i_en=1); overrides i_wr/i_rd.
- i_wr  in  1  write request.
- i_rd  in  1  read request.
- i_data  in  DATA_WIDTH  write data.
- o_data  out  DATA_WIDTH  read data.
- o_valid  out  1  o_data holds a popped word.
- o_level  out  ADDR_WIDTH+1  stored word count, 0..DEPTH.
- o_full, o_empty, o_afull, o_aempty  out  1 each  level flags.
- o_overflow, o_underflow  out  1 each  sticky error flags.

## Operation
- Storage: DEPTH-entry RAM, ADDR_WIDTH-bit read/write pointers wrapping modulo DEPTH, plus a registered level counter. Memory contents are not reset.
- Accept rules (only on edges where i_en=1 and i_clr=0):
  - Read accepted: i_rd=1 and level>0.
  - Write accepted: i_wr=1 and level<DEPTH.
  - Write when full with a read in the same edge: accepted; level stays DEPTH; no overflow.
  - Write when full, no read, OVERWRITE_OLD=1: data stored at wptr; both pointers advance; level stays DEPTH; o_overflow set.
  - Write when full, no read, OVERWRITE_OLD=0: write dropped; o_overflow set.
  - Read when empty: rejected; o_underflow set; a simultaneous write is still accepted.
- Level update: +1 for an accepted write only; −1 for an accepted read only; unchanged for both or neither.
- Flags are decoded from the registered level:
  - o_full = (level==DEPTH)
  - o_empty = (level==0)
  - o_afull = (level ≥ AFULL_THRESH)
  - o_aempty = (level ≤ AEMPTY_THRESH)
- o_overflow and o_underflow are sticky; only reset or i_clr clears them.
- i_clr: pointers and level go to 0, sticky flags clear, o_valid goes to 0, o_data holds its value.
- Reset values: o_data=0, o_valid=0, o_level=0, o_empty=1, o_full=0, o_aempty=1, o_afull=0, o_overflow=0, o_underflow=0.

## Timing
- Write latency: a word written at edge N is readable from edge N+1. o_level and all flags reflect edge N after edge N.
- Registered read port (default):
  - A read accepted at edge N gives o_data=mem[rptr] and o_valid=1 after edge N.
  - o_valid stays high for one cycle per accepted read.
  - Back-to-back reads give one word per cycle.
- Reset: asserting i_rst_n low takes effect immediately, without waiting for a clock edge, from any state. The first edge after release operates normally.
- i_en=0: pointers, level, flags and o_data hold; o_valid is 0 after the next edge.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through read port):
  - o_data = mem[rptr] combinationally.
  - o_valid = !o_empty.
  - i_rd acknowledges and pops the current word at the edge.
  - Read latency is 0.
- FIFO_FWFT_EN undefined: registered read port as described under Timing.

## Test plan
All scenarios use defaults (depth 4, AFULL 3, AEMPTY 1) unless stated.
- Reset: hold i_rst_n=0 with no clock → all outputs at reset values; o_empty=1, o_aempty=1, o_level=0.
- Fill and drain:
  - Write 0x15, 0x16, 0x17, 0x18 → o_level 1, 2, 3, 4; o_aempty deasserts at 2; o_afull asserts at 3; o_full asserts at 4.
  - Fifth write 0x19 → dropped; o_overflow=1.
  - 4 reads → o_data 0x15..0x18, each with o_valid one cycle after its read; o_empty=1 after the last read.
  - With FIFO_FWFT_EN → o_data=0x15 with o_valid=1 before the first read.
- Overwrite (OVERWRITE_OLD=1): write 0x11..0x16 → o_level=4, o_overflow=1; reads return 0x13, 0x14, 0x15, 0x16.
- Underflow and flush:
  - Read while empty → o_underflow=1, o_valid=0, o_level=0.
  - i_clr pulse with level 2 → o_level=0, o_empty=1, both sticky flags 0.
- Simultaneous read and write:
  - At level 2 → o_level stays 2; FIFO order preserved.
  - At full (OVERWRITE_OLD=0) → both accepted, o_level=4, o_overflow stays 0.
- Async reset mid-operation: level 3, pull i_rst_n low between edges → outputs return to reset values before the next edge. After release, writing 0xA5 then reading returns 0xA5.
